// File: rtl/branch_predict_unit.sv
// ID-stage branch resolution with an IF-stage 2-bit BHT predictor and hit/miss statistics.
// Latency: taken/flush/predict are combinational; BHT and counters update on the next rising edge.
// Backpressure: stall_i freezes all state while the outputs stay driven.
module branch_predict_unit #(
    parameter int         WIDTH      = 32,
    parameter int         BHT_DEPTH  = 16,
    parameter int         CNT_WIDTH  = 16,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          pc_if_i,
    output logic                 predict_o,
    input  logic                 Branch_i,
    input  logic                 stall_i,
    input  logic [31:0]          pc_id_i,
    input  logic [2:0]           funct3_i,
    input  logic [WIDTH-1:0]     data1_i,
    input  logic [WIDTH-1:0]     data2_i,
    input  logic                 pred_i,
    output logic                 taken_o,
    output logic                 flush_o,
    output logic [CNT_WIDTH-1:0] branch_cnt_o,
    output logic [CNT_WIDTH-1:0] miss_cnt_o
);
    localparam int IDX = $clog2(BHT_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           bht_q [BHT_DEPTH];
    logic [1:0]           bht_entry_d;
    logic [IDX-1:0]       if_idx;
    logic [IDX-1:0]       id_idx;
    logic                 cond;
    logic                 upd;
    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
    logic                 unused_pc_bits;

    assign if_idx = pc_if_i[IDX+1:2];
    assign id_idx = pc_id_i[IDX+1:2];
    assign unused_pc_bits = ^{pc_if_i[31:IDX+2], pc_if_i[1:0], pc_id_i[31:IDX+2], pc_id_i[1:0]};

    always_comb begin
        cond = 1'b0;
        case (funct3_i)
            3'b000:  cond = (data1_i == data2_i);
            3'b001:  cond = (data1_i != data2_i);
            3'b100:  cond = ($signed(data1_i) <  $signed(data2_i));
            3'b101:  cond = ($signed(data1_i) >= $signed(data2_i));
            3'b110:  cond = (data1_i <  data2_i);
            3'b111:  cond = (data1_i >= data2_i);
            default: cond = 1'b0;
        endcase
    end

    assign taken_o   = Branch_i & cond;
    assign flush_o   = Branch_i & (taken_o ^ pred_i);
    assign predict_o = bht_q[if_idx][1];
    assign upd       = Branch_i & ~stall_i;

    // Read-before-write: a same-index lookup in the update cycle sees the old entry.
    always_comb begin
        bht_entry_d = bht_q[id_idx];
        if (taken_o && bht_q[id_idx] != 2'b11) begin
            bht_entry_d = bht_q[id_idx] + 2'b01;
        end else if (!taken_o && bht_q[id_idx] != 2'b00) begin
            bht_entry_d = bht_q[id_idx] - 2'b01;
        end
    end

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (upd && branch_cnt_q != '1) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
        end
        if (upd && flush_o && miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= INIT_STATE;
            end
        end else if (upd) begin
            bht_q[id_idx] <= bht_entry_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt_o = branch_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed-vector bench: the driver queues hand-computed expectations, a monitor pops and compares them.
module tb_branch_predict_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] pc_if_i = '0;
    logic        predict_o;
    logic        Branch_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [31:0] pc_id_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] data1_i = '0;
    logic [31:0] data2_i = '0;
    logic        pred_i = 1'b0;
    logic        taken_o;
    logic        flush_o;
    logic [3:0]  branch_cnt_o;
    logic [3:0]  miss_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       taken;
        logic       flush;
        logic       predict;
        logic [3:0] bcnt;
        logic [3:0] mcnt;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;

    branch_predict_unit #(
        .WIDTH(32), .BHT_DEPTH(16), .CNT_WIDTH(4), .INIT_STATE(2'b01)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_if_i(pc_if_i), .predict_o(predict_o),
        .Branch_i(Branch_i), .stall_i(stall_i), .pc_id_i(pc_id_i), .funct3_i(funct3_i),
        .data1_i(data1_i), .data2_i(data2_i), .pred_i(pred_i), .taken_o(taken_o),
        .flush_o(flush_o), .branch_cnt_o(branch_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cmp(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one sample strobe per queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor: got strobe expected queued entry");
            end else begin
                e = exp_q.pop_front();
                cmp(e.name, "taken",   {3'b0, taken_o},   {3'b0, e.taken});
                cmp(e.name, "flush",   {3'b0, flush_o},   {3'b0, e.flush});
                cmp(e.name, "predict", {3'b0, predict_o}, {3'b0, e.predict});
                cmp(e.name, "bcnt",    branch_cnt_o,      e.bcnt);
                cmp(e.name, "mcnt",    miss_cnt_o,        e.mcnt);
            end
        end
    end

    task automatic expect_out(input string nm, input logic et, input logic ef, input logic ep,
                              input logic [3:0] eb, input logic [3:0] em);
        exp_t e;
        e.name = nm; e.taken = et; e.flush = ef; e.predict = ep; e.bcnt = eb; e.mcnt = em;
        exp_q.push_back(e);
        -> chk_ev;
        #0;
    endtask

    task automatic drive(input logic br, input logic st, input logic [2:0] f3,
                         input logic [31:0] d1, input logic [31:0] d2, input logic pr,
                         input logic [31:0] pcid, input logic [31:0] pcif);
        @(negedge clk_i);
        Branch_i = br; stall_i = st; funct3_i = f3; data1_i = d1; data2_i = d2;
        pred_i = pr; pc_id_i = pcid; pc_if_i = pcif;
        #1;
    endtask

    initial begin
        // Reset state and combinational outputs while held in reset.
        #1 pc_if_i = 32'h40;
        #1 expect_out("reset", 0, 0, 0, 4'd0, 4'd0);
        Branch_i = 1; funct3_i = 3'b000; data1_i = 5; data2_i = 5; pred_i = 0; pc_id_i = 32'h40;
        #1 expect_out("rst_comb", 1, 1, 0, 4'd0, 4'd0);
        @(negedge clk_i);
        #1 rst_i = 1; Branch_i = 0;

        // Compare semantics with stall held: no state may change.
        drive(1, 1, 3'b100, 32'hFFFF_FFFF, 1, 0, 32'h40, 32'h40); expect_out("blt_neg",   1, 1, 0, 0, 0);
        drive(1, 1, 3'b110, 32'hFFFF_FFFF, 1, 0, 32'h40, 32'h40); expect_out("bltu_big",  0, 0, 0, 0, 0);
        drive(1, 1, 3'b000, 5, 5, 1, 32'h40, 32'h40);             expect_out("beq_eq",    1, 0, 0, 0, 0);
        drive(1, 1, 3'b001, 5, 5, 1, 32'h40, 32'h40);             expect_out("bne_eq",    0, 1, 0, 0, 0);
        drive(1, 1, 3'b101, 32'hFFFF_FFFF, 1, 0, 32'h40, 32'h40); expect_out("bge_neg",   0, 0, 0, 0, 0);
        drive(1, 1, 3'b111, 32'hFFFF_FFFF, 1, 1, 32'h40, 32'h40); expect_out("bgeu_big",  1, 0, 0, 0, 0);
        drive(1, 1, 3'b010, 5, 5, 1, 32'h40, 32'h40);             expect_out("ill_010",   0, 1, 0, 0, 0);
        drive(1, 1, 3'b011, 5, 5, 0, 32'h40, 32'h40);             expect_out("ill_011",   0, 0, 0, 0, 0);
        drive(0, 0, 3'b000, 5, 5, 1, 32'h40, 32'h40);             expect_out("no_branch", 0, 0, 0, 0, 0);

        // Three taken BEQ at 0x40, predicted not-taken: 01 -> 10 -> 11 -> 11.
        drive(1, 0, 3'b000, 5, 5, 0, 32'h40, 32'h40); expect_out("train1", 1, 1, 0, 0, 0);
        drive(1, 0, 3'b000, 5, 5, 0, 32'h40, 32'h40); expect_out("train2", 1, 1, 1, 1, 1);
        drive(1, 0, 3'b000, 5, 5, 0, 32'h40, 32'h40); expect_out("train3", 1, 1, 1, 2, 2);
        drive(0, 0, 3'b000, 5, 5, 0, 32'h40, 32'h43); expect_out("idx_lowbits", 0, 0, 1, 3, 3);
        drive(0, 0, 3'b000, 5, 5, 0, 32'h40, 32'h7C); expect_out("idx_15",      0, 0, 0, 3, 3);

        // 0x80 aliases to index 0: two not-taken updates take 11 -> 10 -> 01.
        drive(1, 0, 3'b000, 5, 6, 1, 32'h80, 32'h40); expect_out("alias1", 0, 1, 1, 3, 3);
        drive(1, 0, 3'b000, 5, 6, 1, 32'h80, 32'h40); expect_out("alias2", 0, 1, 1, 4, 4);
        drive(1, 0, 3'b000, 5, 6, 0, 32'h44, 32'h40); expect_out("hit_nt", 0, 0, 0, 5, 5);
        drive(0, 0, 3'b000, 5, 6, 0, 32'h44, 32'h44); expect_out("idx1",   0, 0, 0, 6, 5);

        // Twenty mispredicted taken BNE at 0x100 (index 0): both counters pin at 15.
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 3'b001, 1, 2, 0, 32'h100, 32'h100);
            expect_out($sformatf("sat%0d", i), 1, 1, (i == 0) ? 1'b0 : 1'b1,
                       (6 + i > 15) ? 4'd15 : 4'(6 + i), (5 + i > 15) ? 4'd15 : 4'(5 + i));
        end
        drive(0, 0, 3'b001, 1, 2, 0, 32'h100, 32'h100); expect_out("sat_hold", 0, 0, 1, 15, 15);

        // Reset pulsed between edges while an update is pending; held across one edge.
        @(negedge clk_i);
        Branch_i = 1; stall_i = 0; funct3_i = 3'b001; data1_i = 1; data2_i = 2; pred_i = 0;
        pc_id_i = 32'h100; pc_if_i = 32'h100;
        #1 rst_i = 0;
        #1 expect_out("rst_async", 1, 1, 0, 0, 0);
        @(negedge clk_i);
        #1 expect_out("rst_held", 1, 1, 0, 0, 0);
        rst_i = 1; Branch_i = 0;
        drive(1, 0, 3'b001, 1, 2, 0, 32'h100, 32'h100); expect_out("post_rst1", 1, 1, 0, 0, 0);
        drive(0, 0, 3'b001, 1, 2, 0, 32'h100, 32'h100); expect_out("post_rst2", 0, 0, 1, 1, 1);

        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
